divider_inverse: RTL and testbench

Sequential shift-and-add unit that rebuilds a dividend from a division result: data_result = quotient_in × divisor_in + remainder_in. It is the inverse of the restoring divider in the lab design. It sits beside the divider to close the loop for self-checking, and can drive the same HEX/LEDR board wrapper. Control is an explicit FSM plus an iteration counter over a small register datapath, with one add-or-skip step and one shift step per multiplier bit.

---
 rtl/divider_inverse.sv | 156 +++++++++++++++
 tb/tb_divider_inverse.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_inverse.sv
// divider_inverse: sequential shift-and-add rebuild of a dividend,
//   data_result = quotient_in * divisor_in + remainder_in.
// The FSM runs one add-or-skip step and one shift step per multiplier bit,
// then adds the remainder in S_FINAL.
// Optional macro DIVIDER_INVERSE_CHECK_EN adds the operand-validity flag err.
// When the macro is not defined, err is tied low.
module divider_inverse #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   quotient_in,
  input  logic [N-1:0]   divisor_in,
  input  logic [N-1:0]   remainder_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] data_result,
  output logic           err
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [N-1:0]     m_r;
  logic [N-1:0]     q_r;
  logic [N-1:0]     r_r;
  logic [N:0]       a_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   data_r;
  logic [2*N-1:0]   sum_s;

  // Product high half concatenated with the shifted-out low half, plus remainder.
  assign sum_s = {a_r[N-1:0], q_r} + {{N{1'b0}}, r_r};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start is only honoured while idle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_ADD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ADD:   state_next_s = S_SHIFT;
      S_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = S_FINAL;
        end else begin
          state_next_s = S_ADD;
        end
      end
      S_FINAL: state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath: operand capture, conditional add, and the {A,Q} right shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_r   <= {N{1'b0}};
      q_r   <= {N{1'b0}};
      r_r   <= {N{1'b0}};
      a_r   <= {(N+1){1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            m_r   <= divisor_in;
            q_r   <= quotient_in;
            r_r   <= remainder_in;
            a_r   <= {(N+1){1'b0}};
            cnt_r <= {CW{1'b0}};
          end
        end
        S_ADD: begin
          if (q_r[0]) begin
            a_r <= {1'b0, a_r[N-1:0]} + {1'b0, m_r};
          end
        end
        S_SHIFT: begin
          a_r   <= {1'b0, a_r[N:1]};
          q_r   <= {a_r[0], q_r[N-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
        end
        S_FINAL: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Registered status outputs and result; busy drops as done rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      data_r <= {(2*N){1'b0}};
    end else begin
      busy_r <= (state_next_s != S_IDLE);
      done_r <= (state_r == S_FINAL);
      if (state_r == S_FINAL) begin
        data_r <= sum_s;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign data_result = data_r;

`ifdef DIVIDER_INVERSE_CHECK_EN
  logic err_r;

  // Flag operand sets no valid division could produce (zero divisor or r >= d).
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (state_r == S_FINAL) begin
      err_r <= (m_r == {N{1'b0}}) | (r_r >= m_r);
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_divider_inverse.sv
// Self-checking bench for divider_inverse (N=4).
// Honours DIVIDER_INVERSE_CHECK_EN when computing the expected err.
module tb_divider_inverse;

  localparam int N = 4;
`ifdef DIVIDER_INVERSE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] q_in, d_in, r_in;
  logic       busy, done, err;
  logic [7:0] data_result;

  divider_inverse #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .quotient_in  (q_in),
    .divisor_in   (d_in),
    .remainder_in (r_in),
    .busy         (busy),
    .done         (done),
    .data_result  (data_result),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] d;
    logic [3:0] r;
    logic [7:0] data;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got data %h with no result expected", data_result);
      end else begin
        mon_e = sb_q.pop_front();
        tests++;
        if (data_result !== mon_e.data) begin
          fails++;
          $display("FAIL data_result: got %h, expected %h", data_result, mon_e.data);
        end
        tests++;
        if (err !== mon_e.err) begin
          fails++;
          $display("FAIL err: got %b, expected %b", err, mon_e.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic [3:0] d, input logic [3:0] r);
    return CHK & ((d == 4'd0) | (r >= d));
  endfunction

  // One full operation: checks busy while running, latency, single-cycle done, hold.
  task automatic run_op(input logic [3:0] q, input logic [3:0] d, input logic [3:0] r,
                        input logic [7:0] ed, input logic ee);
    int  lat;
    bit  got;
    exp_t e;
    lat = -1;
    got = 1'b0;
    @(negedge clk);
    q_in = q; d_in = d; r_in = r; start = 1'b1;
    e.data = ed; e.err = ee;
    sb_q.push_back(e);
    for (int c = 0; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = c;
      end else begin
        chk("busy_running", 32'(busy), 32'd1);
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done within 21 cycles, expected done at 9");
    end else begin
      chk("latency", 32'(lat), 32'd9);
      chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("result_hold", 32'(data_result), 32'(ed));
    end
  endtask

  vec_t tbl[9];
  int   t_done[3];
  int   k;
  int   d0;
  exp_t e1;

  initial begin
    tbl[0] = '{4'd3,  4'd4,  4'd1,  8'h0D, 1'b0};
    tbl[1] = '{4'd15, 4'd15, 4'd14, 8'hEF, 1'b0};
    tbl[2] = '{4'd15, 4'd15, 4'd15, 8'hF0, CHK};
    tbl[3] = '{4'd0,  4'd9,  4'd5,  8'h05, 1'b0};
    tbl[4] = '{4'd7,  4'd0,  4'd0,  8'h00, CHK};
    tbl[5] = '{4'd8,  4'd8,  4'd7,  8'h47, 1'b0};
    tbl[6] = '{4'd10, 4'd12, 4'd11, 8'h83, 1'b0};
    tbl[7] = '{4'd15, 4'd1,  4'd0,  8'h0F, 1'b0};
    tbl[8] = '{4'd0,  4'd0,  4'd0,  8'h00, CHK};

    reset = 1'b1; start = 1'b0; q_in = 4'd0; d_in = 4'd0; r_in = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_data", 32'(data_result), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].data, tbl[i].err);
    end

    for (int i = 0; i < 6; i++) begin
      logic [3:0] rq, rd, rr;
      logic [7:0] ex;
      rq = 4'($urandom_range(15, 0));
      rd = 4'($urandom_range(15, 0));
      rr = 4'($urandom_range(15, 0));
      ex = 8'(rq) * 8'(rd) + 8'(rr);
      run_op(rq, rd, rr, ex, exp_err(rd, rr));
    end

    // Start and operand changes while busy are ignored.
    d0 = done_seen;
    @(negedge clk);
    q_in = 4'd2; d_in = 4'd3; r_in = 4'd0; start = 1'b1;
    e1.data = 8'h06; e1.err = exp_err(4'd3, 4'd0);
    sb_q.push_back(e1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    q_in = 4'd15; d_in = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_protect_one_done", 32'(done_seen - d0), 32'd1);

    // Reset in the middle of an operation abandons it.
    d0 = done_seen;
    @(negedge clk);
    q_in = 4'd6; d_in = 4'd6; r_in = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_data", 32'(data_result), 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset_no_done", 32'(done_seen - d0), 32'd0);
    run_op(4'd5, 4'd5, 4'd4, 8'h1D, 1'b0);

    // Start held high: one operation every 2N+2 cycles.
    e1.data = 8'h01; e1.err = 1'b0;
    for (int i = 0; i < 3; i++) sb_q.push_back(e1);
    k = 0;
    @(negedge clk);
    q_in = 4'd1; d_in = 4'd1; r_in = 4'd0; start = 1'b1;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t_done[k] = cyc;
        k++;
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("cont_done_count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("cont_period_1", 32'(t_done[1] - t_done[0]), 32'd10);
      chk("cont_period_2", 32'(t_done[2] - t_done[1]), 32'd10);
    end
    repeat (12) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
